alu_result_checker: RTL

- Self-checking monitor that sits on the ALU's output side, in parallel with the ALU.
- It samples each operation as operands A, B and opcode, plus the ALU's Result and Zero.
- It recomputes the golden result, compares it with what the ALU produced, and keeps pass/error statistics plus a first-failure snapshot.
- It closes the loop on the ALU stimulus flow: the stimulus side drives the ALU, and this block reads and judges it, both on-chip and in benches.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_golden.sv | 37 +++
 rtl/alu_result_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode constants, checker FSM state type and LUI shift
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110;

    localparam int LUI_SHIFT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_HALT,
        ST_DONE
    } chk_state_t;

endpackage

// File: rtl/alu_golden.sv
// rtl/alu_golden.sv - combinational golden ALU model
// Ports:
//   A, B        operands
//   op          ALU opcode
//   exp_result  expected result (0 for illegal opcodes)
//   exp_zero    expected zero flag
//   illegal     opcode has no defined operation
module alu_golden
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] exp_result,
    output logic             exp_zero,
    output logic             illegal
);

    always_comb begin
        exp_result = '0;
        illegal    = 1'b0;
        case (op)
            ALU_ADD: exp_result = A + B;
            ALU_SUB: exp_result = A - B;
            ALU_AND: exp_result = A & B;
            ALU_OR:  exp_result = A | B;
            ALU_XOR: exp_result = A ^ B;
            ALU_LUI: exp_result = WIDTH'(B[15:0]) << LUI_SHIFT;
            default: illegal    = 1'b1;
        endcase
    end

    assign exp_zero = (exp_result == '0);

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - two-stage ALU result checker with statistics and first-failure snapshot
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, finish            test control pulses
//   chk_valid, chk_ready     sample handshake
//   A, B, ALU_operation      ALU inputs being observed
//   Result, Zero             ALU outputs under check
//   err_pulse                one-cycle pulse per failing sample
//   pass_count, err_count    saturating statistics
//   first_err_op/exp/got     snapshot of the first failure
//   busy, done, pass         run status
module alu_result_checker
    import alu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             chk_valid,
    output logic             chk_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_operation,
    input  logic [WIDTH-1:0] Result,
    input  logic             Zero,
    output logic             err_pulse,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       first_err_op,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    chk_state_t       state;
    chk_state_t       state_nxt;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_result;
    logic             s1_zero;

    logic             s2_valid;
    logic             s2_bad;
    logic [2:0]       s2_op;
    logic [WIDTH-1:0] s2_exp;
    logic [WIDTH-1:0] s2_got;

    logic [WIDTH-1:0] exp_result;
    logic             exp_zero;
    logic             illegal;
    logic             s1_bad;
    logic             accept;
    logic             empty;

    alu_golden #(.WIDTH(WIDTH)) u_golden (
        .A          (s1_a),
        .B          (s1_b),
        .op         (s1_op),
        .exp_result (exp_result),
        .exp_zero   (exp_zero),
        .illegal    (illegal)
    );

    assign accept = chk_valid && chk_ready;
    assign s1_bad = illegal || (s1_result != exp_result) || (s1_zero != exp_zero);
    assign empty  = !s1_valid && !s2_valid;
    assign pass   = done && (err_count == '0) && (pass_count != '0);

    // The halt decision looks at the failure entering S2, so chk_ready drops on
    // the same edge the failing outcome is registered.
    function automatic chk_state_t fsm_next(chk_state_t cur, logic fin, logic fail, logic idle_pipe);
        case (cur)
            ST_IDLE:  fsm_next = ST_IDLE;
            ST_RUN:   fsm_next = fin ? ST_DRAIN : ((STOP_ON_ERR && fail) ? ST_HALT : ST_RUN);
            ST_DRAIN: fsm_next = idle_pipe ? ST_DONE : ST_DRAIN;
            ST_HALT:  fsm_next = fin ? (idle_pipe ? ST_DONE : ST_DRAIN) : ST_HALT;
            ST_DONE:  fsm_next = ST_DONE;
            default:  fsm_next = ST_IDLE;
        endcase
    endfunction

    assign state_nxt = fsm_next(state, finish, s1_valid && s1_bad, empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            chk_ready     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            s1_valid      <= 1'b0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_op         <= '0;
            s1_result     <= '0;
            s1_zero       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_bad        <= 1'b0;
            s2_op         <= '0;
            s2_exp        <= '0;
            s2_got        <= '0;
            err_pulse     <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            first_err_op  <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else if (start) begin
            // Restart wins over everything, including a finish in the same cycle
            // and any sample presented alongside it.
            state         <= ST_RUN;
            chk_ready     <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            err_pulse     <= 1'b0;
            pass_count    <= '0;
            err_count     <= '0;
            first_err_op  <= '0;
            first_err_exp <= '0;
            first_err_got <= '0;
        end else begin
            state     <= state_nxt;
            chk_ready <= (state_nxt == ST_RUN);
            busy      <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
            done      <= (state_nxt == ST_DONE);

            s1_valid <= accept;
            if (accept) begin
                s1_a      <= A;
                s1_b      <= B;
                s1_op     <= ALU_operation;
                s1_result <= Result;
                s1_zero   <= Zero;
            end

            s2_valid <= s1_valid;
            s2_bad   <= s1_bad;
            s2_op    <= s1_op;
            s2_exp   <= exp_result;
            s2_got   <= s1_result;

            err_pulse <= s2_valid && s2_bad;
            if (s2_valid) begin
                if (s2_bad) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (err_count == '0) begin
                        first_err_op  <= s2_op;
                        first_err_exp <= s2_exp;
                        first_err_got <= s2_got;
                    end
                end else if (pass_count != '1) begin
                    pass_count <= pass_count + 1'b1;
                end
            end
        end
    end

endmodule
